regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the MIPS datapath: N_READ registered read ports, two write ports.
//  Replaces the fixed 2R/1W file. Adds per-port read enables, hardwired zero register and a second write port.
//  The second write port serves dual-issue / load-writeback. Sits between decode (read) and writeback (write).
// PARAMETERS
//  DATA_W   32  width of each register and data port
//  ADDR_W   5   register address width
//  DEPTH    32  number of registers implemented (<= 2**ADDR_W)
//  N_READ   2   number of read ports (>= 1)
//  ZERO_REG 1   1: register 0 reads 0, writes to it discarded; 0: register 0 is ordinary
// PORTS
//  clk   in   1               clock; all state updates on rising edge
//  rst   in   1               synchronous reset, active low
//  we0   in   1               write enable, port 0
//  wa0   in   ADDR_W          write address, port 0
//  wd0   in   DATA_W          write data, port 0
//  we1   in   1               write enable, port 1 (priority port)
//  wa1   in   ADDR_W          write address, port 1
//  wd1   in   DATA_W          write data, port 1
//  re    in   N_READ          per-port read enable; bit k = port k
//  ra    in   N_READ*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd    out  N_READ*DATA_W   registered read data, port k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: rst low at rising clk -> all DEPTH registers = 0, rd = 0; writes and reads that cycle ignored.
//  - Write: weN high at rising clk -> reg[waN] <= wdN. Takes effect at that edge.
//  - Dual write, same address, both enabled: port 1 wins; port 0 data dropped; no error.
//  - Dual write, different addresses: both commit in the same cycle.
//  - Write to address >= DEPTH: discarded. Write to reg 0 with ZERO_REG=1: discarded.
//  - Read: re[k] high at rising clk -> rd[k] <= value of reg[ra[k]] (latency 1 cycle).
//  - re[k] low: rd[k] holds previous value (no toggle; power/stall support).
//  - Read of address >= DEPTH returns 0. Read of reg 0 with ZERO_REG=1 returns 0 regardless of history.
//  - All N_READ ports independent; any ports may read the same address in the same cycle.
//  - Read/write same address, same edge: see CONFIGURATION (bypass). Port-1-over-port-0 priority applies to the bypass path too.
//  - Reset mid-operation: any write presented in the reset cycle is lost; first valid access is the cycle after rst returns high.
//  - No combinational path from inputs to rd; rd is a pure register output.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - Read of address being written on the same edge returns the NEW write data (write-through forwarding).
//   - Forwarding obeys discard rules: no bypass for reg 0 (ZERO_REG=1) or address >= DEPTH.
//  REGFILE_BYPASS_EN undefined:
//   - Same-edge read returns the OLD register contents; new value visible from the following read.
//   - Pipeline must handle the hazard (stall or external forwarding).
// TESTING
//  1. rst low 1 cycle after random writes -> every address reads 0; rd = 0 during and after reset.
//  2. we0=1 wa0=5 wd0=0xDEADBEEF; next cycle re=2'b01 ra[0]=5 -> rd[0]=0xDEADBEEF one cycle later.
//  3. we0=1 wa0=7 wd0=0x11, we1=1 wa1=7 wd1=0x22 same edge -> reg 7 reads 0x22.
//  4. wa0=0 wd0=0xFFFFFFFF, ZERO_REG=1 -> reg 0 reads 0; ZERO_REG=0 build -> reads 0xFFFFFFFF.
//  5. reg 3=0xA; same edge we0 wa0=3 wd0=0xB and re[1] ra[1]=3 -> rd[1]=0xB with REGFILE_BYPASS_EN, 0xA without.
//  6. rd[0]=0x55, then re[0]=0 while ra[0] changes and writes occur -> rd[0] stays 0x55 until re[0]=1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: N_READ registered read ports, two write ports (port 1 has priority).
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [N_READ-1:0]          re,
    input  logic [N_READ*ADDR_W-1:0]   ra,
    output logic [N_READ*DATA_W-1:0]   rd
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_p0 [N_READ];
    logic              wr_ok0;
    logic              wr_ok1;

    // Addresses past DEPTH and the hardwired zero register are neither stored nor read back.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok0 = we0 && addr_ok(wa0);
    assign wr_ok1 = we1 && addr_ok(wa1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok1 && (wa1 == ADDR_W'(i)))
                    mem[i] <= wd1;
                else if (wr_ok0 && (wa0 == ADDR_W'(i)))
                    mem[i] <= wd0;
            end
        end
    end

    // Stage p0: read mux (plus optional forwarding); port 1 is applied last so it wins.
    always_comb begin
        for (int k = 0; k < N_READ; k++) begin
            rdata_p0[k] = '0;
            if (addr_ok(ra[k*ADDR_W +: ADDR_W])) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ra[k*ADDR_W +: ADDR_W] == ADDR_W'(i))
                        rdata_p0[k] = mem[i];
                end
`ifdef REGFILE_BYPASS_EN
                if (wr_ok0 && (wa0 == ra[k*ADDR_W +: ADDR_W]))
                    rdata_p0[k] = wd0;
                if (wr_ok1 && (wa1 == ra[k*ADDR_W +: ADDR_W]))
                    rdata_p0[k] = wd1;
`endif
            end
        end
    end

    // Stage p1: registered read data, held while the port is not enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd <= '0;
        end else begin
            for (int k = 0; k < N_READ; k++) begin
                if (re[k])
                    rd[k*DATA_W +: DATA_W] <= rdata_p0[k];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG=1/DEPTH=32 and ZERO_REG=0/DEPTH=24) against an array model.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [NR-1:0] re;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd_a, rd_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .N_READ(NR), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .re(re), .ra(ra), .rd(rd_a));

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(24), .N_READ(NR), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .re(re), .ra(ra), .rd(rd_b));

    // Reference model: per-instance register contents and expected read outputs.
    logic [DW-1:0] model [2][32];
    logic [DW-1:0] exp_rd [2][NR];
    int            depth_of [2] = '{32, 24};
    bit            zr_of [2]    = '{1'b1, 1'b0};
    int            checks = 0;
    int            errors = 0;

    function automatic bit valid(int inst, int a);
        return (a < depth_of[inst]) && !(zr_of[inst] && a == 0);
    endfunction

    function automatic logic [DW-1:0] get_rd(int inst, int k);
        return (inst == 0) ? rd_a[k*DW +: DW] : rd_b[k*DW +: DW];
    endfunction

    task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_ra(int k, int a);
        ra[k*AW +: AW] = AW'(a);
    endtask

    // One clock: predict from current inputs, advance the model, then compare both instances.
    task automatic step();
        for (int inst = 0; inst < 2; inst++) begin
            if (!rst) begin
                for (int i = 0; i < 32; i++) model[inst][i] = '0;
                for (int k = 0; k < NR; k++) exp_rd[inst][k] = '0;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (re[k]) begin
                        int a = int'(ra[k*AW +: AW]);
                        logic [DW-1:0] v = '0;
                        if (valid(inst, a)) begin
                            v = model[inst][a];
`ifdef REGFILE_BYPASS_EN
                            if (we0 && int'(wa0) == a) v = wd0;
                            if (we1 && int'(wa1) == a) v = wd1;
`endif
                        end
                        exp_rd[inst][k] = v;
                    end
                end
                if (we0 && valid(inst, int'(wa0))) model[inst][wa0] = wd0;
                if (we1 && valid(inst, int'(wa1))) model[inst][wa1] = wd1;
            end
        end
        @(posedge clk);
        #1;
        for (int inst = 0; inst < 2; inst++)
            for (int k = 0; k < NR; k++)
                chk($sformatf("rd inst%0d port%0d", inst, k), get_rd(inst, k), exp_rd[inst][k]);
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; re = '0;
    endtask

    task automatic randomize_inputs();
        we0 = 1'($urandom); we1 = 1'($urandom);
        wa0 = AW'($urandom); wa1 = AW'($urandom);
        wd0 = $urandom; wd1 = $urandom;
        re  = NR'($urandom);
        ra  = (NR*AW)'($urandom);
    endtask

    initial begin
        rst = 1'b0; idle(); wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
        step(); step();
        rst = 1'b1;

        // Random traffic to populate the file.
        for (int n = 0; n < 30; n++) begin randomize_inputs(); step(); end

        // Reset with writes pending: everything reads back zero afterwards.
        randomize_inputs(); we0 = 1'b1; we1 = 1'b1; re = '1;
        rst = 1'b0; step();
        chk("rd0 in reset", rd_a[DW-1:0], '0);
        rst = 1'b1; idle();
        for (int i = 0; i < 32; i++) begin
            re = '1; set_ra(0, i); set_ra(1, 31 - i); step();
            chk("post-reset read a", rd_a[DW-1:0], '0);
            chk("post-reset read b", rd_b[DW-1:0], '0);
        end

        // Simple write then read.
        idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; step();
        idle(); re = 2'b01; set_ra(0, 5); step();
        chk("write-read reg5", rd_a[DW-1:0], 32'hDEADBEEF);

        // Same-address dual write: port 1 wins.
        idle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; step();
        idle(); re = 2'b11; set_ra(0, 7); set_ra(1, 7); step();
        chk("dual write p0", rd_a[DW-1:0], 32'h22);
        chk("dual write p1", rd_a[2*DW-1:DW], 32'h22);

        // Register 0: hardwired on u_a, ordinary on u_b.
        idle(); we0 = 1'b1; wa0 = '0; wd0 = 32'hFFFFFFFF; step();
        idle(); re = 2'b01; set_ra(0, 0); step();
        chk("reg0 zero_reg", rd_a[DW-1:0], '0);
        chk("reg0 ordinary", rd_b[DW-1:0], 32'hFFFFFFFF);

        // Out-of-range address on the DEPTH=24 instance.
        idle(); we1 = 1'b1; wa1 = 5'd28; wd1 = 32'h1234; step();
        idle(); re = 2'b10; set_ra(1, 28); step();
        chk("addr28 depth32", rd_a[2*DW-1:DW], 32'h1234);
        chk("addr28 depth24", rd_b[2*DW-1:DW], '0);

        // Same-edge read and write of reg 3.
        idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA; step();
        idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hB; re = 2'b10; set_ra(1, 3); step();
`ifdef REGFILE_BYPASS_EN
        chk("same-edge read", rd_a[2*DW-1:DW], 32'hB);
`else
        chk("same-edge read", rd_a[2*DW-1:DW], 32'hA);
`endif
        idle(); re = 2'b10; set_ra(1, 3); step();
        chk("read after write", rd_a[2*DW-1:DW], 32'hB);

        // Hold: rd[0] keeps its value while re[0] is low.
        idle(); we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55; step();
        idle(); re = 2'b01; set_ra(0, 9); step();
        chk("hold setup", rd_a[DW-1:0], 32'h55);
        for (int n = 0; n < 6; n++) begin
            randomize_inputs(); re[0] = 1'b0;
            if (n == 2) begin we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h66; end
            step();
            chk("hold rd0", rd_a[DW-1:0], 32'h55);
        end
        idle(); we1 = 1'b0; re = 2'b01; set_ra(0, 9); step();

        // Long random run against the model.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            if (n % 97 == 50) rst = 1'b0; else rst = 1'b1;
            step();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
